// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, with pipeline stall and a one-cycle done pulse.
module muldiv_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  flush,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic            neg_q, neg_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic [W-1:0]    result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            a_signed, b_signed, sa, sb;
    logic [W-1:0]    mag_a, mag_b;
    logic            div_zero, div_ovf;
    logic [W:0]      mul_sum, div_trial;
    logic [2*W-1:0]  mul_next, div_next, acc_iter, prod_fix;
    logic [W-1:0]    mul_res, div_val, div_res, final_res;

    always_comb begin
        // Operand decode for the op being offered on the inputs
        a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                   (Funct3 == 3'b100) || (Funct3 == 3'b110);
        b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sa       = a_signed & SrcA[W-1];
        sb       = b_signed & SrcB[W-1];
        mag_a    = sa ? (~SrcA + 1'b1) : SrcA;
        mag_b    = sb ? (~SrcB + 1'b1) : SrcB;
        div_zero = Funct3[2] && (SrcB == '0);
        div_ovf  = Funct3[2] && !Funct3[0] && (SrcA == MIN_NEG) && (SrcB == '1);

        // acc holds {product_hi, multiplier} for MUL* and {remainder, quotient} for DIV*
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[W-1:1]};
        div_trial = {acc_q[2*W-1:W], acc_q[W-1]} - {1'b0, opnd_q};
        div_next  = div_trial[W] ? {acc_q[2*W-2:W], acc_q[W-1], acc_q[W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        acc_iter  = op_q[2] ? div_next : mul_next;

        prod_fix  = neg_q ? (~acc_iter + 1'b1) : acc_iter;
        mul_res   = (op_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        div_val   = op_q[1] ? acc_iter[2*W-1:W] : acc_iter[W-1:0];
        div_res   = neg_q ? (~div_val + 1'b1) : div_val;
        final_res = op_q[2] ? div_res : mul_res;

        state_d  = state_q;
        count_d  = count_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d    = Funct3;
                    count_d = '0;
                    // REM takes the dividend's sign; everything else the product of signs
                    neg_d   = (Funct3[2] && Funct3[1]) ? sa : (sa ^ sb);
                    if (div_zero) begin
                        result_d = Funct3[1] ? SrcA : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = Funct3[1] ? '0 : MIN_NEG;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = Funct3[2] ? {{W{1'b0}}, mag_a} : {{W{1'b0}}, mag_b};
                        opnd_d  = Funct3[2] ? mag_b : mag_a;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = acc_iter;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(W - 1)) begin
                        result_d = final_res;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, sign rules, special divides,
// flush and asynchronous reset behaviour.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        flush;
    logic        busy, stall, done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .Funct3(Funct3),
        .SrcA(SrcA), .SrcB(SrcB), .flush(flush),
        .busy(busy), .stall(stall), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle start is sampled; done must appear exactly lat cycles later
    task automatic wait_done(input string tag, input logic [31:0] exp, input int lat);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k < lat) chk({tag, " calc"}, {29'd0, busy, stall, done}, 32'd6);
        end
        chk({tag, " done"}, {29'd0, busy, stall, done}, 32'd1);
        chk({tag, " result"}, Result, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit hold);
        Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
        #1;
        chk({tag, " stall0"}, {31'd0, stall}, 32'd1);
        wait_done(tag, exp, lat);
        if (!hold) begin
            start = 1'b0;
            step();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = 3'b000; SrcA = '0; SrcB = '0;
        #12;
        chk("reset outs", {29'd0, busy, stall, done}, 32'd0);
        chk("reset result", Result, 32'd0);
        reset = 1'b0;
        step();

        run_op("mul 7x6",      3'b000, 32'd7,        32'd6,        32'd42,        33, 0);
        run_op("mulh -1x-1",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,       33, 0);
        run_op("mulhu",        3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
        run_op("mulhsu",       3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("mul -3x5",     3'b000, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFF1, 33, 0);
        run_op("mulh -3x5",    3'b001, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 33, 0);
        run_op("mulhu 2^31x4", 3'b011, 32'h8000_0000, 32'd4,        32'd2,         33, 0);
        run_op("div -7/2",     3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 0);
        run_op("rem -7/2",     3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 0);
        run_op("div 7/-2",     3'b100, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        run_op("rem 7/-2",     3'b110, 32'd7,        32'hFFFF_FFFE, 32'd1,         33, 0);
        run_op("divu 100/7",   3'b101, 32'd100,      32'd7,        32'd14,        33, 0);
        run_op("remu 100/7",   3'b111, 32'd100,      32'd7,        32'd2,         33, 0);
        run_op("div 5/0",      3'b100, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  0);
        run_op("rem 5/0",      3'b110, 32'd5,        32'd0,        32'd5,         1,  0);
        run_op("divu 5/0",     3'b101, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  0);
        run_op("div ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("rem ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1,  0);

        // flush together with start in IDLE: not accepted
        Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1; flush = 1'b1;
        #1;
        chk("idle flush stall", {31'd0, stall}, 32'd0);
        step();
        start = 1'b0; flush = 1'b0;
        chk("idle flush busy", {29'd0, busy, stall, done}, 32'd0);

        // flush at count=10 (cycle 11 after start)
        start = 1'b1;
        for (int k = 0; k < 11; k++) step();
        chk("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1; start = 1'b0;
        step();
        flush = 1'b0;
        chk("flush outs", {29'd0, busy, stall, done}, 32'd0);
        chk("flush result held", Result, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("flush no done", {31'd0, done}, 32'd0);
        end
        run_op("after flush",  3'b000, 32'd9,        32'd11,       32'd99,        33, 0);

        // async reset at count=20 (cycle 21)
        Funct3 = 3'b011; SrcA = 32'd5; SrcB = 32'd5; start = 1'b1;
        for (int k = 0; k < 21; k++) step();
        #2;
        reset = 1'b1; start = 1'b0;
        #1;
        chk("async rst outs", {29'd0, busy, stall, done}, 32'd0);
        chk("async rst result", Result, 32'd0);
        #1;
        reset = 1'b0;
        step();

        // start held across done: re-sampled the cycle after done
        run_op("held 1st",     3'b000, 32'd7,        32'd6,        32'd42,        33, 1);
        step();
        chk("held idle", {29'd0, busy, stall, done}, 32'd2);
        wait_done("held 2nd", 32'd42, 33);
        start = 1'b0;
        step();
        chk("final idle", {29'd0, busy, stall, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
